// File: rtl/debounce_switch_io.sv
// debounce_switch_io: synchronises a raw bouncing switch/key to clk and qualifies it into a clean level plus rise/fall strobes
//   clk          : system clock, all state updates on posedge
//   rst_n        : synchronous reset, active-low
//   switch_raw   : raw asynchronous switch/key pin
//   switch_clean : debounced level, 1 = pressed/on (registered)
//   rise / fall  : one-cycle strobes on switch_clean 0->1 / 1->0 (registered)
module debounce_switch_io #(
   parameter int STABLE_CYCLES = 1000000,
   parameter int CNT_W         = 20,
   parameter bit ACTIVE_LOW    = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic switch_raw,
   output logic switch_clean,
   output logic rise,
   output logic fall
);
   typedef enum logic [1:0] {IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW} state_t;
   localparam logic IDLE_LVL = ACTIVE_LOW;
   localparam logic [CNT_W-1:0] C_STABLE = CNT_W'(STABLE_CYCLES);
   logic r_sync1, r_sync2;
   state_t r_state;
   logic [CNT_W-1:0] r_cnt;
   logic w_s;
   // normalised sample: 1 = pressed regardless of pin polarity
   assign w_s = r_sync2 ^ IDLE_LVL;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sync1      <= IDLE_LVL;
         r_sync2      <= IDLE_LVL;
         r_state      <= IDLE_LOW;
         r_cnt        <= '0;
         switch_clean <= 1'b0;
         rise         <= 1'b0;
         fall         <= 1'b0;
      end else begin
         r_sync1 <= switch_raw;
         r_sync2 <= r_sync1;
         rise    <= 1'b0;
         fall    <= 1'b0;
         case (r_state)
            IDLE_LOW: begin
               r_state <= w_s ? WAIT_HIGH : IDLE_LOW;
               r_cnt   <= w_s ? CNT_W'(1) : '0;
            end
            WAIT_HIGH: begin
               // any reversion aborts qualification without touching outputs
               if (!w_s) begin
                  r_state <= IDLE_LOW;
                  r_cnt   <= '0;
               end else if (r_cnt == C_STABLE) begin
                  r_state      <= IDLE_HIGH;
                  switch_clean <= 1'b1;
                  rise         <= 1'b1;
                  r_cnt        <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            IDLE_HIGH: begin
               r_state <= !w_s ? WAIT_LOW : IDLE_HIGH;
               r_cnt   <= !w_s ? CNT_W'(1) : '0;
            end
            WAIT_LOW: begin
               if (w_s) begin
                  r_state <= IDLE_HIGH;
                  r_cnt   <= '0;
               end else if (r_cnt == C_STABLE) begin
                  r_state      <= IDLE_LOW;
                  switch_clean <= 1'b0;
                  fall         <= 1'b1;
                  r_cnt        <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
         endcase
      end
   end
endmodule
